// File: rtl/m_spi_pkg.sv
// Shared constants and state encoding for the 64-bit SPI slave.
package m_spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 32;
    localparam int unsigned FRAME_WIDTH    = 64;
    localparam int unsigned SPI_CNT_W      = $clog2(SPI_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/m_spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin with rise/fall detection
// on the synchronised level.
module m_spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/m_64spi_slave.sv
// SPI mode-0 slave receiving/sending 64-bit frames as two SS_N-delimited 32-bit words.
// Define SLV_TIMEOUT_EN to abandon a half-received frame after TIMEOUT_CYCLES idle clocks.
module m_64spi_slave
    import m_spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SCLK_SLAVE,
    input  logic                   SS_N_SLAVE,
    input  logic                   MOSI_SLAVE,
    output logic                   MISO_SLAVE,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   word_idx
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
    logic w_unused_sclk, w_unused_ss, w_unused_mosi_rise, w_unused_mosi_fall;

    m_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(clk), .i_reset(reset), .i_async(SCLK_SLAVE),
        .o_sync(w_unused_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    m_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk(clk), .i_reset(reset), .i_async(SS_N_SLAVE),
        .o_sync(w_unused_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    m_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk), .i_reset(reset), .i_async(MOSI_SLAVE),
        .o_sync(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    spi_state_e                  r_state;
    logic [2*DATA_WIDTH-1:0]     r_tx_buf;
    logic [DATA_WIDTH-1:0]       r_tx_shift, r_rx_shift, r_rx_buf0, r_rx_buf1;
    logic [CNT_W-1:0]            r_bit_cnt;
    logic [FRAME_WIDTH-1:0]      r_rx_data;
    logic                        r_miso, r_rx_valid, r_busy, r_word_idx, r_frame_pend;
    logic                        r_def_rise, r_def_fall;
    logic                        w_rise, w_fall;

    // SCLK edges coinciding with the SS_N fall are replayed on the first SHIFT cycle.
    assign w_rise = w_sclk_rise | r_def_rise;
    assign w_fall = w_sclk_fall | r_def_fall;

`ifdef SLV_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_tx_buf     <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_rx_buf0    <= '0;
            r_rx_buf1    <= '0;
            r_bit_cnt    <= '0;
            r_rx_data    <= '0;
            r_miso       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_word_idx   <= 1'b0;
            r_frame_pend <= 1'b0;
            r_def_rise   <= 1'b0;
            r_def_fall   <= 1'b0;
`ifdef SLV_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_rx_valid   <= 1'b0;
            r_def_rise   <= 1'b0;
            r_def_fall   <= 1'b0;
            r_frame_pend <= 1'b0;
            if (r_frame_pend) begin
                r_rx_data  <= {r_rx_buf1, r_rx_buf0};
                r_rx_valid <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall) begin
                        if (!r_word_idx) begin
                            r_tx_buf   <= tx_data;
                            r_busy     <= 1'b1;
                            r_tx_shift <= tx_data[DATA_WIDTH-1:0];
                            r_miso     <= tx_data[DATA_WIDTH-1];
                        end else begin
                            r_tx_shift <= r_tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_miso     <= r_tx_buf[2*DATA_WIDTH-1];
                        end
                        r_bit_cnt  <= '0;
                        r_def_rise <= w_sclk_rise;
                        r_def_fall <= w_sclk_fall;
                        r_state    <= StShift;
                    end
                end
                StShift: begin
                    if (w_ss_rise) begin
                        // Short word: dropped, word_idx and rx buffers untouched.
                        r_miso  <= 1'b0;
                        r_state <= StIdle;
                    end else if (w_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            r_miso  <= 1'b0;
                            r_state <= StDone;
                        end
                    end else if (w_fall) begin
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                        r_miso     <= r_tx_shift[DATA_WIDTH-2];
                    end
                end
                StDone: begin
                    r_miso <= 1'b0;
                    if (w_ss_rise) begin
                        if (r_word_idx) begin
                            r_rx_buf1    <= r_rx_shift;
                            r_frame_pend <= 1'b1;
                            r_busy       <= 1'b0;
                            r_word_idx   <= 1'b0;
                        end else begin
                            r_rx_buf0  <= r_rx_shift;
                            r_word_idx <= 1'b1;
                        end
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_miso  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
`ifdef SLV_TIMEOUT_EN
            if (w_ss_fall || r_state != StIdle || !r_word_idx) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                r_tmo_cnt  <= '0;
                r_word_idx <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
`endif
        end
    end

    assign MISO_SLAVE = r_miso;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign busy       = r_busy;
    assign word_idx   = r_word_idx;

endmodule
